// File: rtl/gauss_pkg.sv
// Shared definitions for the 3x3 Gaussian window generator and its computing block:
// corner-position codes, the window-generator FSM encoding, and the corner decode helper.
package gauss_pkg;

    localparam int CT_WIDTH = 4;

    localparam logic [CT_WIDTH-1:0] CT_NONE  = 4'd0;
    localparam logic [CT_WIDTH-1:0] CT_TL    = 4'd1;
    localparam logic [CT_WIDTH-1:0] CT_TR    = 4'd2;
    localparam logic [CT_WIDTH-1:0] CT_LEFT  = 4'd3;
    localparam logic [CT_WIDTH-1:0] CT_RIGHT = 4'd4;
    localparam logic [CT_WIDTH-1:0] CT_BL    = 4'd5;
    localparam logic [CT_WIDTH-1:0] CT_BR    = 4'd6;
    localparam logic [CT_WIDTH-1:0] CT_EDGE  = 4'd7;
    localparam logic [CT_WIDTH-1:0] CT_INNER = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_EOL   = 2'd2,
        ST_FLUSH = 2'd3
    } gauss_state_t;

    // Top and bottom rows share CT_EDGE for their interior columns.
    function automatic logic [CT_WIDTH-1:0] corner_code(input logic row_first, input logic row_last,
                                                        input logic col_first, input logic col_last);
        logic [CT_WIDTH-1:0] code;
        if (row_first)
            code = col_first ? CT_TL : (col_last ? CT_TR : CT_EDGE);
        else if (row_last)
            code = col_first ? CT_BL : (col_last ? CT_BR : CT_EDGE);
        else
            code = col_first ? CT_LEFT : (col_last ? CT_RIGHT : CT_INNER);
        return code;
    endfunction

endpackage

// File: rtl/gauss_line_buf.sv
// One image line of storage: combinational read, write on the clock edge, so a read and a
// write to the same address in one cycle return the old contents.
module gauss_line_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640,
    parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/gauss_window_gen.sv
// Raster pixel stream -> registered 3x3 window per pixel with out-of-image taps zeroed.
// Optional WINDOW_SIDEBAND_EN adds win_sof / win_eol markers alongside each window.
module gauss_window_gen
    import gauss_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    input  logic [DATA_WIDTH-1:0] pix_in,
    output logic                  pix_ready,
    output logic                  win_valid,
    output logic [DATA_WIDTH-1:0] line0_data0,
    output logic [DATA_WIDTH-1:0] line0_data1,
    output logic [DATA_WIDTH-1:0] line0_data2,
    output logic [DATA_WIDTH-1:0] line1_data0,
    output logic [DATA_WIDTH-1:0] line1_data1,
    output logic [DATA_WIDTH-1:0] line1_data2,
    output logic [DATA_WIDTH-1:0] line2_data0,
    output logic [DATA_WIDTH-1:0] line2_data1,
    output logic [DATA_WIDTH-1:0] line2_data2,
`ifdef WINDOW_SIDEBAND_EN
    output logic                  win_sof,
    output logic                  win_eol,
`endif
    output logic [CT_WIDTH-1:0]   corner_type
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    gauss_state_t state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d, eff_row, ctr_row;
    logic [COL_W-1:0] col_q, col_d, eff_col, ctr_col, rd_addr;
    logic accept, shift, emit;
    logic [DATA_WIDTH-1:0] new_top, lb1_rd, lb2_rd;

    // Columns are packed top-to-bottom as [0]=line0 (newest row) .. [2]=line2 (oldest row).
    logic [2:0][DATA_WIDTH-1:0] col_new, sr0_q, sr0_d, sr1_q, sr1_d;
    logic [2:0][2:0][DATA_WIDTH-1:0] win_cols, tap_q, tap_d;
    logic win_valid_q;
    logic [CT_WIDTH-1:0] corner_q, corner_d;
`ifdef WINDOW_SIDEBAND_EN
    logic win_sof_q, win_sof_d, win_eol_q, win_eol_d;
`endif

    assign pix_ready = !rst && (state_q == ST_IDLE || state_q == ST_RUN);
    assign accept    = pix_valid && pix_ready;

    // An accept in IDLE, or any accept flagged pix_sof, restarts the frame at (0,0).
    assign eff_row = (state_q != ST_RUN || pix_sof) ? '0 : row_q;
    assign eff_col = (state_q != ST_RUN || pix_sof) ? '0 : col_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        shift   = 1'b0;
        emit    = 1'b0;
        ctr_row = '0;
        ctr_col = '0;
        rd_addr = col_q;
        new_top = '0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                rd_addr = eff_col;
                new_top = pix_in;
                if (accept) begin
                    shift   = 1'b1;
                    state_d = ST_RUN;
                    emit    = (eff_row != '0) && (eff_col != '0);
                    ctr_row = eff_row - 1'b1;
                    ctr_col = eff_col - 1'b1;
                    if (eff_col != COL_LAST) begin
                        row_d = eff_row;
                        col_d = eff_col + 1'b1;
                    end else if (eff_row == '0) begin
                        row_d = ROW_W'(1);
                        col_d = '0;
                    end else begin
                        state_d = ST_EOL;
                        row_d   = eff_row;
                        col_d   = '0;
                    end
                end
            end
            // Reading address 0 here leaves column 0 in sr0 for the first flush window.
            ST_EOL: begin
                rd_addr = '0;
                shift   = 1'b1;
                emit    = 1'b1;
                ctr_row = row_q - 1'b1;
                ctr_col = COL_LAST;
                col_d   = '0;
                if (row_q == ROW_LAST) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                    row_d   = row_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                rd_addr = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                shift   = 1'b1;
                emit    = 1'b1;
                ctr_row = ROW_LAST;
                ctr_col = col_q;
                if (col_q == COL_LAST) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Window assembly: data0 is the column just formed, data1/data2 the two held columns.
    always_comb begin
        col_new     = {lb2_rd, lb1_rd, new_top};
        sr0_d       = shift ? col_new : sr0_q;
        sr1_d       = shift ? sr0_q : sr1_q;
        win_cols    = {sr1_q, sr0_q, col_new};
        tap_d       = '0;
        corner_d    = CT_NONE;
        if (emit) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) begin
                    if (!((k == 0 && ctr_row == ROW_LAST) || (k == 2 && ctr_row == '0) ||
                          (j == 0 && ctr_col == COL_LAST) || (j == 2 && ctr_col == '0)))
                        tap_d[k][j] = win_cols[j][k];
                end
            end
            corner_d = corner_code(ctr_row == '0, ctr_row == ROW_LAST,
                                   ctr_col == '0, ctr_col == COL_LAST);
        end
`ifdef WINDOW_SIDEBAND_EN
        win_sof_d = emit && (ctr_row == '0) && (ctr_col == '0);
        win_eol_d = emit && (ctr_col == COL_LAST);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            sr0_q       <= '0;
            sr1_q       <= '0;
            tap_q       <= '0;
            win_valid_q <= 1'b0;
            corner_q    <= CT_NONE;
`ifdef WINDOW_SIDEBAND_EN
            win_sof_q   <= 1'b0;
            win_eol_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            sr0_q       <= sr0_d;
            sr1_q       <= sr1_d;
            tap_q       <= tap_d;
            win_valid_q <= emit;
            corner_q    <= corner_d;
`ifdef WINDOW_SIDEBAND_EN
            win_sof_q   <= win_sof_d;
            win_eol_q   <= win_eol_d;
`endif
        end
    end

    // lb_row1 holds the previous row, lb_row2 the row before it; lb_row2 inherits lb_row1's old word.
    gauss_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) lb_row1 (
        .clk(clk), .we(accept), .addr(rd_addr), .wdata(pix_in), .rdata(lb1_rd)
    );

    gauss_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) lb_row2 (
        .clk(clk), .we(accept), .addr(rd_addr), .wdata(lb1_rd), .rdata(lb2_rd)
    );

    assign win_valid   = win_valid_q;
    assign corner_type = corner_q;
    assign line0_data0 = tap_q[0][0];
    assign line0_data1 = tap_q[0][1];
    assign line0_data2 = tap_q[0][2];
    assign line1_data0 = tap_q[1][0];
    assign line1_data1 = tap_q[1][1];
    assign line1_data2 = tap_q[1][2];
    assign line2_data0 = tap_q[2][0];
    assign line2_data1 = tap_q[2][1];
    assign line2_data2 = tap_q[2][2];
`ifdef WINDOW_SIDEBAND_EN
    assign win_sof     = win_sof_q;
    assign win_eol     = win_eol_q;
`endif

endmodule

// File: tb/tb_gauss_window_gen.sv
// Directed bench for gauss_window_gen on a 4x3 image with pixel value 16*r+c.
module tb_gauss_window_gen;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;

    typedef struct packed {
        logic [3:0]        corner;
        logic [8:0][DW-1:0] taps;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pix_valid = 1'b0;
    logic pix_sof = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic pix_ready, win_valid;
    logic [DW-1:0] l0d0, l0d1, l0d2, l1d0, l1d1, l1d2, l2d0, l2d1, l2d2;
    logic [3:0] corner_type;
`ifdef WINDOW_SIDEBAND_EN
    logic win_sof, win_eol;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    win_t wq[$];
    int ready_runs[$];
    int low_run = 0;
    int corner_tab[12] = '{1, 7, 7, 2, 3, 8, 8, 4, 5, 7, 7, 6};

    gauss_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_in(pix_in),
        .pix_ready(pix_ready), .win_valid(win_valid),
        .line0_data0(l0d0), .line0_data1(l0d1), .line0_data2(l0d2),
        .line1_data0(l1d0), .line1_data1(l1d1), .line1_data2(l1d2),
        .line2_data0(l2d0), .line2_data1(l2d1), .line2_data2(l2d2),
`ifdef WINDOW_SIDEBAND_EN
        .win_sof(win_sof), .win_eol(win_eol),
`endif
        .corner_type(corner_type)
    );

    always #5 clk = ~clk;

    // Window capture and pix_ready low-run measurement, both sampled on the falling edge.
    always @(negedge clk) begin
        if (win_valid)
            wq.push_back({corner_type, l2d2, l2d1, l2d0, l1d2, l1d1, l1d0, l0d2, l0d1, l0d0});
        if (rst) begin
            low_run = 0;
        end else if (!pix_ready) begin
            low_run++;
        end else if (low_run > 0) begin
            ready_runs.push_back(low_run);
            low_run = 0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int r, input int c, input bit sof, input int gap_pct);
        int guard = 0;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            pix_valid = 1'b0;
            @(posedge clk); #1;
        end
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_in    = DW'(16 * r + c);
        while (!pix_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!pix_ready)
            checkOutput("ready_timeout", {71'd0, pix_ready}, 72'd1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic sendFrame(input int gap_pct);
        for (int i = 0; i < W * H; i++)
            applyStimulus(i / W, i % W, i == 0, gap_pct);
    endtask

    task automatic waitWindows(input int n, input string tag);
        int budget = 0;
        while (wq.size() < n && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        repeat (8) @(posedge clk);
        #1;
        checkOutput({tag, "_count"}, 72'(wq.size()), 72'(n));
    endtask

    function automatic logic [71:0] expTaps(input int r, input int c);
        logic [8:0][DW-1:0] t;
        int row, col;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                row = r + 1 - k;
                col = c + 1 - j;
                t[k * 3 + j] = (row < 0 || row >= H || col < 0 || col >= W) ? '0 : DW'(16 * row + col);
            end
        end
        return 72'(t);
    endfunction

    task automatic checkFrame(input string tag);
        for (int i = 0; i < W * H && i < wq.size(); i++) begin
            checkOutput($sformatf("%s_w%0d_corner", tag, i), 72'(wq[i].corner), 72'(corner_tab[i]));
            checkOutput($sformatf("%s_w%0d_taps", tag, i), 72'(wq[i].taps), expTaps(i / W, i % W));
        end
    endtask

    task automatic checkRuns(input string tag);
        checkOutput({tag, "_runs"}, 72'(ready_runs.size()), 72'd2);
        if (ready_runs.size() >= 2) begin
            checkOutput({tag, "_eol_low"}, 72'(ready_runs[0]), 72'd1);
            checkOutput({tag, "_flush_low"}, 72'(ready_runs[1]), 72'd5);
        end
    endtask

    initial begin
        int n_before;

        // Reset held three cycles: everything quiet, then ready in the first cycle after release.
        #2 rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("rst_win_valid", {71'd0, win_valid}, 72'd0);
            checkOutput("rst_pix_ready", {71'd0, pix_ready}, 72'd0);
        end
        checkOutput("rst_corner", 72'(corner_type), 72'd0);
        checkOutput("rst_taps", {l0d0, l0d1, l0d2, l1d0, l1d1, l1d2, l2d0, l2d1, l2d2}, 72'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", {71'd0, pix_ready}, 72'd1);

        // Full frame, no gaps.
        wq.delete();
        ready_runs.delete();
        sendFrame(0);
        waitWindows(12, "full");
        if (wq.size() > 0) begin
            checkOutput("first_corner", 72'(wq[0].corner), 72'd1);
            checkOutput("first_l0d0", 72'(wq[0].taps[0]), 72'd17);
            checkOutput("first_l0d1", 72'(wq[0].taps[1]), 72'd16);
            checkOutput("first_l1d0", 72'(wq[0].taps[3]), 72'd1);
            checkOutput("first_l2d0", 72'(wq[0].taps[6]), 72'd0);
        end
        if (wq.size() > 7)
            checkOutput("eol_corner_13", 72'(wq[7].corner), 72'd4);
        checkFrame("full");
        checkRuns("full");
        checkOutput("idle_ready", {71'd0, pix_ready}, 72'd1);

        // Same frame with about half the cycles idle on the input.
        wq.delete();
        ready_runs.delete();
        sendFrame(50);
        waitWindows(12, "gaps");
        checkFrame("gaps");
        checkRuns("gaps");

        // Abandon a frame after six pixels; only window (0,0) of it may appear.
        wq.delete();
        for (int i = 0; i < 6; i++)
            applyStimulus(i / W, i % W, i == 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("partial_count", 72'(wq.size()), 72'd1);
        wq.delete();
        ready_runs.delete();
        sendFrame(0);
        waitWindows(12, "sof");
        checkFrame("sof");

        // Reset in the middle of the flush, then a clean frame.
        wq.delete();
        sendFrame(0);
        @(posedge clk);
        @(posedge clk);
        #3;
        checkOutput("flush_valid", {71'd0, win_valid}, 72'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {71'd0, win_valid}, 72'd0);
        checkOutput("mid_rst_ready", {71'd0, pix_ready}, 72'd0);
        n_before = wq.size();
        checkOutput("pre_rst_count", 72'(n_before), 72'd8);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_no_win", 72'(wq.size()), 72'(n_before));
        rst = 1'b0;
        #1;
        wq.delete();
        ready_runs.delete();
        sendFrame(0);
        waitWindows(12, "after_rst");
        checkFrame("after_rst");
        checkRuns("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
